fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
//  Instruction-fetch sequencer for the RV core: owns the PC register, issues one
//  req/gnt/rvalid fetch at a time to instruction memory, hands fetched words to decode.
//  Applies redirects resolved in EX from pc_src_a/pc_src_b (PC+imm or rs1+imm)
//  and discards the stale in-flight fetch.
// PARAMETERS
//  XLEN      32            datapath / address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk          in   1     core clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  br_valid     in   1     EX branch/jump resolution valid this cycle
//  pc_src_a     in   1     1 = take redirect (from branch condition logic)
//  pc_src_b     in   1     0 = target br_pc+imm, 1 = target rs1_data+imm
//  br_pc        in   XLEN  PC of the resolving instruction
//  imm          in   XLEN  sign-extended offset
//  rs1_data     in   XLEN  rs1 operand for JALR
//  stall        in   1     decode cannot accept; hold current instruction
//  imem_req     out  1     fetch request
//  imem_addr    out  XLEN  fetch address, word aligned
//  imem_gnt     in   1     request accepted (sampled with imem_req)
//  imem_rvalid  in   1     read data valid (>=1 cycle after gnt)
//  imem_rdata   in   32    fetched instruction word
//  inst_valid   out  1     inst/inst_pc valid to decode
//  inst         out  32    instruction word
//  inst_pc      out  XLEN  address of inst
//  misalign     out  1     1-cycle pulse: taken target had bits[1:0]!=0
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0,
//   inst=32'h0000_0013 (NOP), inst_pc=0, misalign=0, kill=0, pend=0.
//  redirect = br_valid & pc_src_a; target = pc_src_b ? (rs1_data+imm) : (br_pc+imm),
//   XLEN-bit add, carry dropped; target[0] cleared; target[1]=1 -> misalign pulse,
//   target[1:0] forced to 2'b00. Sequential next = pc+4, wraps modulo 2^XLEN.
//  FSM (at most one outstanding fetch):
//   IDLE: 1 cycle after reset release -> REQ with imem_addr=pc.
//   REQ : imem_req=1; imem_addr stable until gnt. gnt -> WAIT.
//   WAIT: imem_req=0. rvalid & !kill -> latch inst/inst_pc, inst_valid=1, pc+=4,
//         -> HOLD if stall at that edge else REQ. rvalid & kill -> drop, kill=0, -> REQ.
//   HOLD: inst_valid/inst/inst_pc held while stall=1; stall=0 -> REQ next cycle.
//  inst_valid is a 1-cycle pulse unless held in HOLD; decode consumes on inst_valid&!stall.
//  Fetch latency: gnt in the REQ cycle + rvalid next cycle => REQ to inst_valid = 2 cycles.
//  Redirect (highest priority, any state):
//   IDLE/HOLD: pc=target, inst_valid->0 next cycle, -> REQ.
//   REQ, no gnt same cycle: imem_addr updated to target next cycle (not yet accepted).
//   REQ with gnt same cycle: kill=1, pc=target, -> WAIT; response dropped.
//   WAIT (incl. rvalid same cycle): response dropped (or kill=1 if not yet
//     returned), pc=target, inst_valid=0.
//   A redirect never raises inst_valid for the killed word.
//  Simultaneous redirect+stall: redirect wins; held instruction discarded.
//  rvalid outside WAIT is ignored (stale response across reset).
//  Async reset mid-fetch: all state to reset values immediately; refetch RESET_PC.
// TESTING
//  1 reset release, gnt same cycle, rvalid +1 -> addrs 0x0,0x4,0x8; inst_valid
//    each 2 cycles, inst_pc matching.
//  2 stall=1 for 3 cycles while inst_valid=1 -> inst/inst_pc unchanged, no new
//    imem_req until stall drops.
//  3 redirect pc_src_a=1,pc_src_b=0,br_pc=0x100,imm=0x20 during WAIT ->
//    response dropped, next imem_addr=0x120.
//  4 JALR pc_src_b=1,rs1=0x203,imm=0x1 -> target 0x204; misalign=0. rs1=0x202,
//    imm=0 -> misalign pulse, addr 0x200.
//  5 gnt held low 4 cycles in REQ -> imem_addr stable; redirect there -> addr
//    changes to target, no kill.
//  6 rst_n low while in WAIT, rvalid arrives during IDLE -> ignored;
//    first inst_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fetch_seq
// Purpose  : Instruction-fetch sequencer. Owns the PC, keeps at most one
//            req/gnt/rvalid fetch in flight to instruction memory, hands
//            fetched words to decode and applies EX-stage redirects,
//            discarding any stale in-flight response.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  input  logic            pc_src_a,
  input  logic            pc_src_b,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign
);

  // ADDI x0,x0,0 - shown to decode whenever no real word has been fetched
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // one settling cycle after reset release
    ST_REQ  = 2'd1,  // request on the bus, waiting for grant
    ST_WAIT = 2'd2,  // granted, waiting for read data
    ST_HOLD = 2'd3   // word presented to decode, decode is stalling
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            kill_q, kill_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misalign_q, misalign_d;

  logic            redirect;
  logic [XLEN-1:0] tgt_sum;
  logic [XLEN-1:0] target;
  logic            tgt_misalign;
  logic [XLEN-1:0] pc_inc;

  // Redirect target: PC-relative or register-relative add, carry dropped.
  // Bit 0 is simply cleared (JALR semantics); a set bit 1 is reported as a
  // misaligned target and the fetch is forced onto the word boundary.
  always_comb begin
    redirect     = br_valid & pc_src_a;
    tgt_sum      = pc_src_b ? (rs1_data + imm) : (br_pc + imm);
    tgt_misalign = tgt_sum[1];
    target       = tgt_sum & ~XLEN'(3);
    pc_inc       = pc_q + XLEN'(4);
  end

  // Next-state and datapath updates; a redirect overrides every other
  // transition so a killed word can never reach decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    kill_d       = kill_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    misalign_d   = redirect & tgt_misalign;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) begin
          pc_d   = target;
          addr_d = target;
        end else begin
          addr_d = pc_q;
        end
      end

      ST_REQ: begin
        if (redirect) begin
          pc_d = target;
          if (imem_gnt) begin
            // Old address already accepted: let it return, then drop it.
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            // Not yet accepted, so the request can simply be retargeted.
            addr_d = target;
          end
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect) begin
          pc_d = target;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            addr_d  = target;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            addr_d  = pc_q;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_inc;
            addr_d       = pc_inc;
            state_d      = stall ? ST_HOLD : ST_REQ;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          addr_d  = target;
          state_d = ST_REQ;
        end else if (stall) begin
          inst_valid_d = 1'b1;
        end else begin
          addr_d  = pc_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset refetches from RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INSN;
      inst_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign misalign   = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fetch_seq
// Purpose  : Directed self-checking bench for fetch_seq with a one-deep
//            memory model and an expected-instruction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic        pc_src_a = 1'b0;
  logic        pc_src_b = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_seq #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_valid   (br_valid),
    .pc_src_a   (pc_src_a),
    .pc_src_b   (pc_src_b),
    .br_pc      (br_pc),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .misalign   (misalign)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          n_deliv = 0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] last_pc = '0;
  logic [31:0] last_inst = '0;
  logic [31:0] rv_addr = '0;
  logic        gnt_en = 1'b1;
  logic        rv_block = 1'b0;
  logic        rv_pend = 1'b0;
  logic        drop_next = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},      32'(imem_req),   32'd0);
    chk({tag, "_addr"},     imem_addr,       RESET_PC);
    chk({tag, "_valid"},    32'(inst_valid), 32'd0);
    chk({tag, "_inst"},     inst,            NOP_INSN);
    chk({tag, "_inst_pc"},  inst_pc,         32'd0);
    chk({tag, "_misalign"}, 32'(misalign),   32'd0);
  endtask

  task automatic set_redirect(input logic src_b, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] im);
    br_valid = 1'b1;
    pc_src_a = 1'b1;
    pc_src_b = src_b;
    br_pc    = pc;
    rs1_data = rs1;
    imm      = im;
  endtask

  task automatic clr_redirect();
    br_valid = 1'b0;
    pc_src_a = 1'b0;
  endtask

  // One clock: called and returns at a falling edge. Drives the memory
  // model, checks the request address against the model PC, records grants
  // in the scoreboard and checks any word handed to decode.
  task automatic tick();
    logic        grant_now;
    logic        prev_valid;
    logic        prev_stall;
    logic [31:0] gaddr;
    exp_t        e;
    imem_gnt    = imem_req & gnt_en;
    imem_rvalid = rv_pend & ~rv_block;
    imem_rdata  = imem_rvalid ? mem_word(rv_addr) : 32'hDEAD_BEEF;
    if (imem_req === 1'b1) chk("req_addr", imem_addr, exp_addr);
    grant_now  = imem_req & gnt_en;
    gaddr      = imem_addr;
    prev_valid = inst_valid;
    prev_stall = stall;
    @(posedge clk);
    if (imem_rvalid) rv_pend = 1'b0;
    if (grant_now) begin
      rv_pend = 1'b1;
      rv_addr = gaddr;
      if (drop_next) begin
        drop_next = 1'b0;
      end else begin
        e.pc   = exp_addr;
        e.word = mem_word(exp_addr);
        sb.push_back(e);
        exp_addr = exp_addr + 32'd4;
      end
    end
    @(negedge clk);
    if (inst_valid === 1'b1) begin
      if (prev_valid && prev_stall) begin
        chk("hold_inst", inst, last_inst);
        chk("hold_inst_pc", inst_pc, last_pc);
      end else begin
        chk("sb_occupancy", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("inst_word", inst, e.word);
          chk("inst_pc", inst_pc, e.pc);
          last_inst = e.word;
          last_pc   = e.pc;
          n_deliv++;
        end
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    exp_addr = RESET_PC;

    // 1: back-to-back fetches 0x0, 0x4, 0x8, one word every two cycles
    repeat (7) tick();
    chk("t1_deliveries", 32'(n_deliv), 32'd3);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: decode stalls on 0xC for three cycles
    tick();
    stall = 1'b1;
    tick();
    repeat (3) begin
      tick();
      chk("t2_no_req", 32'(imem_req), 32'd0);
      chk("t2_valid_held", 32'(inst_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("t2_req_resumes", 32'(imem_req), 32'd1);

    // 3: redirect in WAIT with rvalid in the same cycle -> 0x120
    tick();
    sb.delete(sb.size() - 1);
    set_redirect(1'b0, 32'h100, 32'h0, 32'h20);
    tick();
    clr_redirect();
    exp_addr = 32'h120;
    chk("t3_misalign", 32'(misalign), 32'd0);
    tick();

    // 3b: redirect in WAIT before rvalid -> kill, late response dropped
    rv_block = 1'b1;
    sb.delete(sb.size() - 1);
    set_redirect(1'b0, 32'h300, 32'h0, 32'hFFFF_FFF0);
    tick();
    clr_redirect();
    rv_block = 1'b0;
    exp_addr = 32'h2F0;
    tick();
    chk("t3b_req_after_kill", 32'(imem_req), 32'd1);
    repeat (2) tick();

    // 4: JALR redirect in REQ with gnt the same cycle, target 0x204
    set_redirect(1'b1, 32'h0, 32'h203, 32'h1);
    drop_next = 1'b1;
    tick();
    clr_redirect();
    exp_addr = 32'h204;
    chk("t4_aligned_no_pulse", 32'(misalign), 32'd0);
    repeat (3) tick();
    // misaligned JALR target 0x202 -> fetch 0x200 with a misalign pulse
    gnt_en = 1'b0;
    set_redirect(1'b1, 32'h0, 32'h202, 32'h0);
    tick();
    clr_redirect();
    exp_addr = 32'h200;
    chk("t4_misalign_pulse", 32'(misalign), 32'd1);

    // 5: grant withheld, address stays put; redirect retargets without kill
    repeat (4) begin
      tick();
      chk("t5_req_held", 32'(imem_req), 32'd1);
      chk("t5_misalign_low", 32'(misalign), 32'd0);
    end
    set_redirect(1'b0, 32'h400, 32'h0, 32'h40);
    tick();
    clr_redirect();
    exp_addr = 32'h440;
    gnt_en = 1'b1;
    repeat (2) tick();

    // PC wrap: fetch 0xFFFF_FFFC, sequential successor is 0x0
    gnt_en = 1'b0;
    set_redirect(1'b0, 32'hFFFF_FF00, 32'h0, 32'hFC);
    tick();
    clr_redirect();
    exp_addr = 32'hFFFF_FFFC;
    gnt_en = 1'b1;
    repeat (2) tick();

    // Redirect while stalled in HOLD; adder carry dropped (0xFFFF_FFF0+0x34)
    tick();
    stall = 1'b1;
    repeat (2) tick();
    set_redirect(1'b1, 32'h0, 32'hFFFF_FFF0, 32'h34);
    tick();
    clr_redirect();
    chk("hold_redirect_drops_valid", 32'(inst_valid), 32'd0);
    stall = 1'b0;
    exp_addr = 32'h24;
    repeat (2) tick();

    // 6: async reset while in WAIT; stale rvalid lands in IDLE
    tick();
    rv_block = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    sb.delete();
    exp_addr = RESET_PC;
    tick();
    rst_n = 1'b1;
    rv_block = 1'b0;
    tick();
    chk("t6_stale_ignored", 32'(inst_valid), 32'd0);
    repeat (2) tick();
    chk("t6_first_pc", last_pc, RESET_PC);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("total_deliveries", 32'(n_deliv), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
